// File: rtl/serial_fifo_bridge.sv
// Byte bridge between an external host and the processor serial port: an RX FIFO (host->CPU)
// and a TX FIFO (CPU->host). Define SERIAL_FIFO_BRIDGE_LOOPBACK_EN to route TX straight into RX.

module serial_fifo_bridge_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head_data,
   output logic          not_empty,
   output logic          not_full,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // Requests are qualified here so callers may pass raw valid/rden strobes.
   assign push_ok   = push & not_full;
   assign pop_ok    = pop & not_empty;
   assign not_empty = (count != '0);
   assign not_full  = (count != FULL);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end

   // Storage has no reset: contents are meaningless until written.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   a_count_range : assert property (@(posedge clock) disable iff (reset) count <= FULL);

endmodule

module serial_fifo_bridge #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               host_rx_data,
   input  logic                     host_rx_valid,
   output logic                     host_rx_ready,
   output logic [7:0]               host_tx_data,
   output logic                     host_tx_valid,
   input  logic                     host_tx_ready,
   output logic [7:0]               cpu_data_out,
   output logic                     cpu_valid_out,
   output logic                     cpu_ready_out,
   input  logic                     cpu_rden_in,
   input  logic [7:0]               cpu_data_in,
   input  logic                     cpu_wren_in,
   output logic                     tx_overflow,
   output logic [$clog2(DEPTH):0]   rx_count,
   output logic [$clog2(DEPTH):0]   tx_count
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int NFIFO = 2;
   localparam int RX    = 0;
   localparam int TX    = 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("serial_fifo_bridge: DEPTH must be a power of two >= 2");
   end

   logic [NFIFO-1:0]          push;
   logic [NFIFO-1:0]          pop;
   logic [NFIFO-1:0][7:0]     push_data;
   logic [NFIFO-1:0][7:0]     head_data;
   logic [NFIFO-1:0]          not_empty;
   logic [NFIFO-1:0]          not_full;
   logic [NFIFO-1:0][CW-1:0]  count;

   for (genvar f = 0; f < NFIFO; f++) begin : g_fifo
      serial_fifo_bridge_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[f]),
         .push_data (push_data[f]),
         .pop       (pop[f]),
         .head_data (head_data[f]),
         .not_empty (not_empty[f]),
         .not_full  (not_full[f]),
         .count     (count[f])
      );
   end

   // CPU side is identical in both builds.
   assign pop[RX]       = cpu_rden_in;
   assign push[TX]      = cpu_wren_in;
   assign push_data[TX] = cpu_data_in;
   assign cpu_data_out  = head_data[RX];
   assign cpu_valid_out = not_empty[RX];
   assign cpu_ready_out = not_full[TX];
   assign rx_count      = count[RX];
   assign tx_count      = count[TX];

`ifdef SERIAL_FIFO_BRIDGE_LOOPBACK_EN
   logic lb_move;
   logic unused_host;

   // One byte per edge hops from the TX head into RX; the host port is fenced off.
   assign lb_move       = not_empty[TX] & not_full[RX];
   assign push[RX]      = lb_move;
   assign push_data[RX] = head_data[TX];
   assign pop[TX]       = lb_move;
   assign host_rx_ready = 1'b0;
   assign host_tx_valid = 1'b0;
   assign host_tx_data  = 8'h00;
   assign unused_host   = ^{host_rx_data, host_rx_valid, host_tx_ready};
`else
   assign push[RX]      = host_rx_valid;
   assign push_data[RX] = host_rx_data;
   assign pop[TX]       = host_tx_ready;
   assign host_rx_ready = not_full[RX];
   assign host_tx_valid = not_empty[TX];
   assign host_tx_data  = head_data[TX];
`endif

   // Sticky until reset: a CPU write arrived while TX had no room.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         tx_overflow <= 1'b0;
      else if (cpu_wren_in && !not_full[TX])
         tx_overflow <= 1'b1;
   end

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Directed bench for serial_fifo_bridge (DEPTH=8); follows the loopback build when
// SERIAL_FIFO_BRIDGE_LOOPBACK_EN is defined.

module tb_serial_fifo_bridge;

   localparam int DEPTH = 8;

   logic       clock;
   logic       reset;
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;
   logic [7:0] cpu_data_out;
   logic       cpu_valid_out;
   logic       cpu_ready_out;
   logic       cpu_rden_in;
   logic [7:0] cpu_data_in;
   logic       cpu_wren_in;
   logic       tx_overflow;
   logic [3:0] rx_count;
   logic [3:0] tx_count;

   int n_cmp = 0;
   int n_bad = 0;

   serial_fifo_bridge #(.DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .cpu_data_out  (cpu_data_out),
      .cpu_valid_out (cpu_valid_out),
      .cpu_ready_out (cpu_ready_out),
      .cpu_rden_in   (cpu_rden_in),
      .cpu_data_in   (cpu_data_in),
      .cpu_wren_in   (cpu_wren_in),
      .tx_overflow   (tx_overflow),
      .rx_count      (rx_count),
      .tx_count      (tx_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      host_rx_data  = 8'h00;
      host_rx_valid = 1'b0;
      host_tx_ready = 1'b0;
      cpu_rden_in   = 1'b0;
      cpu_data_in   = 8'h00;
      cpu_wren_in   = 1'b0;

      // Reset state, before any clock edge
      #2;
      chk("rst_rx_count", rx_count, 0);
      chk("rst_tx_count", tx_count, 0);
      chk("rst_cpu_valid", cpu_valid_out, 0);
      chk("rst_host_tx_valid", host_tx_valid, 0);
      chk("rst_cpu_ready", cpu_ready_out, 1);
      chk("rst_overflow", tx_overflow, 0);
`ifdef SERIAL_FIFO_BRIDGE_LOOPBACK_EN
      chk("rst_host_rx_ready", host_rx_ready, 0);
`else
      chk("rst_host_rx_ready", host_rx_ready, 1);
`endif
      step();
      reset = 1'b0;

`ifdef SERIAL_FIFO_BRIDGE_LOOPBACK_EN
      // Host port must stay inert while looping back
      host_rx_valid = 1'b1;
      host_rx_data  = 8'hEE;
      host_tx_ready = 1'b1;
      cpu_wren_in   = 1'b1;
      cpu_data_in   = 8'h5A;
      step();
      cpu_wren_in = 1'b0;
      chk("lb_tx_count1", tx_count, 1);
      chk("lb_valid_early", cpu_valid_out, 0);
      step();
      chk("lb_valid", cpu_valid_out, 1);
      chk("lb_data", cpu_data_out, 8'h5A);
      chk("lb_rx_count", rx_count, 1);
      chk("lb_tx_count0", tx_count, 0);
      chk("lb_host_tx_valid", host_tx_valid, 0);
      chk("lb_host_rx_ready", host_rx_ready, 0);
      cpu_rden_in = 1'b1;
      step();
      cpu_rden_in = 1'b0;
      chk("lb_empty", cpu_valid_out, 0);
      cpu_wren_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_data_in = 8'hC1 + 8'(i);
         step();
      end
      cpu_wren_in = 1'b0;
      step();
      chk("lb_burst_count", rx_count, 3);
      cpu_rden_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("lb_burst_data", cpu_data_out, 8'hC1 + 8'(i));
         step();
      end
      cpu_rden_in = 1'b0;
      chk("lb_burst_empty", cpu_valid_out, 0);
      chk("lb_no_host_tx", host_tx_valid, 0);
`else
      // Two host bytes, CPU pops them
      host_rx_valid = 1'b1;
      host_rx_data  = 8'h41;
      step();
      chk("b1_valid", cpu_valid_out, 1);
      chk("b1_data", cpu_data_out, 8'h41);
      chk("b1_count", rx_count, 1);
      host_rx_data = 8'h42;
      step();
      host_rx_valid = 1'b0;
      chk("b2_head", cpu_data_out, 8'h41);
      chk("b2_count", rx_count, 2);
      cpu_rden_in = 1'b1;
      step();
      chk("pop1_data", cpu_data_out, 8'h42);
      chk("pop1_count", rx_count, 1);
      step();
      chk("pop2_valid", cpu_valid_out, 0);
      chk("pop2_count", rx_count, 0);
      step();
      chk("pop_empty_ignored", rx_count, 0);
      cpu_rden_in = 1'b0;

      // Fill RX, hold off the ninth byte, pop to release it
      host_rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         host_rx_data = 8'h10 + 8'(i);
         step();
      end
      chk("full_count", rx_count, 8);
      chk("full_ready", host_rx_ready, 0);
      host_rx_data = 8'h99;
      step();
      step();
      chk("full_held_count", rx_count, 8);
      chk("full_head", cpu_data_out, 8'h10);
      cpu_rden_in = 1'b1;
      step();
      cpu_rden_in = 1'b0;
      chk("unfull_count", rx_count, 7);
      chk("unfull_ready", host_rx_ready, 1);
      step();
      host_rx_valid = 1'b0;
      chk("refill_count", rx_count, 8);
      cpu_rden_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("wrap_rx_data", cpu_data_out, (i < 7) ? 8'h11 + 8'(i) : 8'h99);
         step();
      end
      cpu_rden_in = 1'b0;
      chk("wrap_rx_empty", cpu_valid_out, 0);

      // Simultaneous push and pop keeps count
      host_rx_valid = 1'b1;
      host_rx_data  = 8'hA0;
      step();
      host_rx_data = 8'hA1;
      cpu_rden_in  = 1'b1;
      step();
      host_rx_valid = 1'b0;
      chk("pp_count", rx_count, 1);
      chk("pp_data", cpu_data_out, 8'hA1);
      step();
      cpu_rden_in = 1'b0;
      chk("pp_drain", rx_count, 0);

      // TX overflow: nine writes, host stalled
      host_tx_ready = 1'b0;
      cpu_wren_in   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cpu_data_in = 8'h60 + 8'(i);
         step();
      end
      chk("tx_full_count", tx_count, 8);
      chk("tx_full_ready", cpu_ready_out, 0);
      chk("tx_no_ovf_yet", tx_overflow, 0);
      chk("tx_host_valid", host_tx_valid, 1);
      chk("tx_head", host_tx_data, 8'h60);
      cpu_data_in = 8'h68;
      step();
      cpu_wren_in = 1'b0;
      chk("ovf_set", tx_overflow, 1);
      chk("ovf_count", tx_count, 8);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("tx_drain_data", host_tx_data, 8'h60 + 8'(i));
         step();
      end
      host_tx_ready = 1'b0;
      chk("tx_drained", host_tx_valid, 0);
      chk("ovf_sticky", tx_overflow, 1);

      // Stream 20 bytes through TX with a stuttering host
      begin
         int sent = 0;
         int rcv  = 0;
         int cyc  = 0;
         logic       take;
         logic [7:0] got;
         while (rcv < 20 && cyc < 300) begin
            cpu_wren_in   = (sent < 20) && cpu_ready_out;
            cpu_data_in   = 8'(32'h80 + sent);
            host_tx_ready = (cyc % 3) != 0;
            take = host_tx_valid && host_tx_ready;
            got  = host_tx_data;
            step();
            if (cpu_wren_in) sent++;
            if (take) begin
               chk("stream_data", got, 8'(32'h80 + rcv));
               rcv++;
            end
            cyc++;
         end
         cpu_wren_in   = 1'b0;
         host_tx_ready = 1'b0;
         chk("stream_received", rcv, 20);
         chk("stream_tx_empty", tx_count, 0);
      end

      // Asynchronous reset with traffic in flight
      host_rx_valid = 1'b1;
      cpu_wren_in   = 1'b1;
      cpu_data_in   = 8'h71;
      for (int i = 0; i < 3; i++) begin
         host_rx_data = 8'h31 + 8'(i);
         if (i == 2) cpu_wren_in = 1'b0;
         step();
      end
      host_rx_valid = 1'b0;
      chk("pre_rst_rx", rx_count, 3);
      chk("pre_rst_tx", tx_count, 2);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_rx_count", rx_count, 0);
      chk("arst_tx_count", tx_count, 0);
      chk("arst_cpu_valid", cpu_valid_out, 0);
      chk("arst_host_tx_valid", host_tx_valid, 0);
      chk("arst_host_rx_ready", host_rx_ready, 1);
      chk("arst_cpu_ready", cpu_ready_out, 1);
      chk("arst_overflow", tx_overflow, 0);
      #2;
      reset = 1'b0;
      host_rx_valid = 1'b1;
      host_rx_data  = 8'h55;
      step();
      host_rx_valid = 1'b0;
      chk("post_rst_count", rx_count, 1);
      chk("post_rst_data", cpu_data_out, 8'h55);
      cpu_rden_in = 1'b1;
      step();
      cpu_rden_in = 1'b0;
      chk("post_rst_empty", cpu_valid_out, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
